mem_stage: RTL and testbench

Data-memory access stage placed between the EX/MEM pipeline register and the MEM/WB register. It consumes the execute stage's ALU result (as address) and forwarded store data, and runs RISC-V byte, halfword and word loads and stores over a req/ack data-memory port. It produces the value written back (`memResult`) and asserts `stall` to freeze the upstream pipeline while an access is outstanding.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: FSM encoding,
// funct3 access-size codes and byte-enable patterns.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] carries the size for both signed and unsigned variants.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = ~addr_lo[0];
      2'b10:   ok = (addr_lo == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store-side enable/data replication and load-side
// lane extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic [2:0]               st_funct3,
  input  logic [1:0]               st_addr_lo,
  input  logic [WORD_BITWIDTH-1:0] store_data,
  output logic [3:0]               st_be,
  output logic [WORD_BITWIDTH-1:0] st_wdata,
  input  logic [2:0]               ld_funct3,
  input  logic [1:0]               ld_addr_lo,
  input  logic [WORD_BITWIDTH-1:0] rdata,
  output logic [WORD_BITWIDTH-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    st_be    = BE_WORD;
    st_wdata = store_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_be    = BE_BYTE << st_addr_lo;
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be    = st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte   = rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half   = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign ld_signed = ~ld_funct3[2];

  always_comb begin
    ld_data = rdata;
    case (ld_funct3[1:0])
      2'b00:   ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls
// upstream until the response, and selects the write-back value.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter int ADDR_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] ALUresult,
  input  logic [WORD_BITWIDTH-1:0] storeData,
  output logic [WORD_BITWIDTH-1:0] memResult,
  output logic                     stall,
  output logic                     accessFault,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [3:0]               dmem_be,
  output logic [ADDR_BITWIDTH-1:0] dmem_addr,
  output logic [WORD_BITWIDTH-1:0] dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [WORD_BITWIDTH-1:0] dmem_rdata,
  output mem_state_e               dbg_state
);

  mem_state_e state, state_nxt;

  logic                     is_mem, legal, aligned, in_idle, start, fault;
  logic                     load_q;
  logic [2:0]               ld_funct3_q;
  logic [1:0]               ld_addr_lo_q;
  logic [WORD_BITWIDTH-1:0] loadData;
  logic [3:0]               st_be;
  logic [WORD_BITWIDTH-1:0] st_wdata, ld_data;

  assign is_mem  = valid & (memRead | memWrite);
  assign legal   = f3_legal(funct3);
  assign aligned = f3_aligned(funct3, ALUresult[1:0]);
  assign in_idle = (state == ST_IDLE);
  assign start   = in_idle & is_mem & legal & aligned;
  assign fault   = in_idle & is_mem & ~(legal & aligned);

  mem_lane_align #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_align (
    .st_funct3  (funct3),
    .st_addr_lo (ALUresult[1:0]),
    .store_data (storeData),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (ld_funct3_q),
    .ld_addr_lo (ld_addr_lo_q),
    .rdata      (dmem_rdata),
    .ld_data    (ld_data)
  );

  // Handshake: dmem_req rises with stable addr/we/be/wdata and stays up until
  // the first cycle dmem_ack is seen in BUSY; that cycle completes the access
  // (rdata valid for reads). Ack outside BUSY carries no meaning.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_BUSY;
      ST_BUSY: if (dmem_ack) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_be      <= BE_NONE;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      load_q       <= 1'b0;
      ld_funct3_q  <= 3'b000;
      ld_addr_lo_q <= 2'b00;
      loadData     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        // memWrite wins when both read and write are flagged.
        dmem_req     <= 1'b1;
        dmem_we      <= memWrite;
        dmem_be      <= memWrite ? st_be : BE_WORD;
        dmem_addr    <= {ALUresult[ADDR_BITWIDTH-1:2], 2'b00};
        dmem_wdata   <= memWrite ? st_wdata : '0;
        load_q       <= ~memWrite;
        ld_funct3_q  <= funct3;
        ld_addr_lo_q <= ALUresult[1:0];
      end
      if ((state == ST_BUSY) && dmem_ack) begin
        dmem_req <= 1'b0;
        if (load_q) loadData <= ld_data;
      end
    end
  end

  assign stall       = start | (state == ST_BUSY);
  assign accessFault = fault;
  assign memResult   = fault ? '0 :
                       ((state == ST_RESP) && load_q) ? loadData : ALUresult;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a byte-addressed reference memory predicts
// load results; a word-wide device model answers the DUT's requests.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUresult, storeData, memResult;
  logic        stall, accessFault;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  mem_state_e  dbg_state;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [7:0]  ref_mem [64];
  logic [31:0] dev_mem [16];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid(valid), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .ALUresult(ALUresult), .storeData(storeData),
    .memResult(memResult), .stall(stall), .accessFault(accessFault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input int gap);
    logic        is_mem, fault;
    int          size, off, stall_cnt, widx;
    logic [31:0] exp_be, exp_wd, exp_res, mask;
    valid = v; memRead = rd; memWrite = wr; funct3 = f3;
    ALUresult = a; storeData = sd; dmem_ack = 1'b0;
    #1;
    is_mem = v & (rd | wr);
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    fault  = is_mem && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((a % size) != 0));
    if (!is_mem) begin
      check("alu_result", memResult, a);
      check("alu_stall", {31'd0, stall}, 0);
      check("alu_fault", {31'd0, accessFault}, 0);
      step();
      check("alu_no_req", {31'd0, dmem_req}, 0);
      return;
    end
    if (fault) begin
      check("fault_flag", {31'd0, accessFault}, 1);
      check("fault_stall", {31'd0, stall}, 0);
      check("fault_result", memResult, 0);
      step();
      check("fault_no_req", {31'd0, dmem_req}, 0);
      return;
    end
    check("issue_stall", {31'd0, stall}, 1);
    check("issue_fault", {31'd0, accessFault}, 0);
    off    = int'(a - 32'h100);
    exp_be = wr ? (((32'd1 << size) - 1) << (off % 4)) : 32'hF;
    exp_wd = (size == 1) ? sd[7:0] * 32'h01010101 :
             (size == 2) ? sd[15:0] * 32'h00010001 : sd;
    step();
    stall_cnt = 1;
    check("req_high", {31'd0, dmem_req}, 1);
    check("req_we", {31'd0, dmem_we}, {31'd0, wr});
    check("req_be", {28'd0, dmem_be}, exp_be);
    check("req_addr", dmem_addr, a & ~32'd3);
    if (wr) check("req_wdata", dmem_wdata, exp_wd);
    for (int i = 0; i <= gap; i++) begin
      check("busy_stall", {31'd0, stall}, 1);
      check("busy_req", {31'd0, dmem_req}, 1);
      check("busy_addr", dmem_addr, a & ~32'd3);
      stall_cnt++;
      if (i == gap) begin
        dmem_ack = 1'b1;
        widx = int'((dmem_addr - 32'h100) >> 2) & 15;
        if (dmem_we) begin
          for (int b = 0; b < 4; b++)
            if (dmem_be[b]) dev_mem[widx][8*b +: 8] = dmem_wdata[8*b +: 8];
        end else begin
          dmem_rdata = dev_mem[widx];
        end
      end
      step();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    if (wr) begin
      exp_res = a;
      for (int b = 0; b < size; b++) ref_mem[off + b] = 8'(sd >> (8 * b));
    end else begin
      exp_res = 0;
      for (int b = 0; b < size; b++) exp_res = exp_res | (32'(ref_mem[off + b]) << (8 * b));
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 1;
        if (!f3[2] && ((exp_res >> (8 * size - 1)) & 32'd1) == 32'd1) exp_res = exp_res | ~mask;
      end
    end
    check("resp_stall", {31'd0, stall}, 0);
    check("resp_req", {31'd0, dmem_req}, 0);
    check("resp_fault", {31'd0, accessFault}, 0);
    check("resp_state", {30'd0, dbg_state}, {30'd0, ST_RESP});
    check("resp_result", memResult, exp_res);
    check("stall_cycles", stall_cnt, gap + 2);
    step();
    check("back_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
  endtask

  initial begin
    int          r;
    logic        v, rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  f3_tab [10];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 16; w++)
      dev_mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

    rst = 1'b1; valid = 0; memRead = 0; memWrite = 0; funct3 = 0;
    ALUresult = 0; storeData = 0; dmem_ack = 0; dmem_rdata = 0;
    step();
    check("rst_req", {31'd0, dmem_req}, 0);
    check("rst_we", {31'd0, dmem_we}, 0);
    check("rst_be", {28'd0, dmem_be}, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_fault", {31'd0, accessFault}, 0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    step();

    do_op(1, 0, 1, F3_W,  32'h100, 32'hDEADBEEF, 1);
    do_op(1, 0, 1, F3_B,  32'h103, 32'h000000A5, 0);
    do_op(1, 1, 0, F3_W,  32'h100, 32'h0, 2);
    do_op(1, 0, 1, F3_W,  32'h100, 32'h00800000, 0);
    do_op(1, 1, 0, F3_B,  32'h102, 32'h0, 0);
    do_op(1, 1, 0, F3_BU, 32'h102, 32'h0, 1);
    do_op(1, 1, 0, F3_H,  32'h101, 32'h0, 0);
    do_op(1, 0, 0, F3_B,  32'h1234, 32'h0, 0);
    do_op(1, 1, 1, F3_H,  32'h10A, 32'h0000CAFE, 0);

    // Reset while an access is outstanding.
    valid = 1; memRead = 0; memWrite = 1; funct3 = F3_W;
    ALUresult = 32'h120; storeData = 32'h5A5A5A5A;
    step();
    check("pre_rst_req", {31'd0, dmem_req}, 1);
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, dmem_req}, 0);
    check("async_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    valid = 0; memWrite = 0;
    step();
    rst = 1'b0;
    dmem_ack = 1'b1;
    step();
    check("stray_ack_req", {31'd0, dmem_req}, 0);
    check("stray_ack_stall", {31'd0, stall}, 0);
    check("stray_ack_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    dmem_ack = 1'b0;
    do_op(1, 1, 0, F3_W, 32'h120, 32'h0, 0);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      f3 = f3_tab[$urandom_range(0, 9)];
      if (r < 2) begin
        v  = 1'($urandom_range(0, 1));
        rd = v ? 1'b0 : 1'($urandom_range(0, 1));
        wr = v ? 1'b0 : 1'($urandom_range(0, 1));
        a  = $urandom;
      end else begin
        v = 1'b1;
        {rd, wr} = 2'($urandom_range(1, 3));
        a = 32'h100 + 32'($urandom_range(0, 63));
      end
      do_op(v, rd, wr, f3, a, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
